// File: rtl/eBike_pkg.sv
// Shared constants, widths and settle-FSM state type for the incline datapath.
package eBike_pkg;

  localparam logic signed [15:0] PTCH_RT_OFFSET = 16'sh0050;
  localparam logic signed [15:0] AZ_OFFSET      = 16'shFEE0;
  localparam int unsigned        FUSION_STEP    = 1024;
  localparam int unsigned        ACC_GAIN       = 327;

  localparam int unsigned INCLINE_W  = 13;
  localparam int unsigned PTCH_INT_W = 27;

  typedef enum logic {
    SETTLING = 1'b0,
    RUN      = 1'b1
  } settle_state_e;

endpackage

// File: rtl/ptch_acc_calc.sv
// Accelerometer-derived pitch: offset-correct AZ, scale by ACC_GAIN, keep prod[25:13].
module ptch_acc_calc
  import eBike_pkg::*;
(
  input  logic signed [15:0] i_az,
  output logic signed [15:0] o_ptch_acc
);

  logic signed [15:0] w_az_comp;
  logic signed [25:0] w_az_sext;
  logic signed [25:0] w_prod;

  assign w_az_comp = i_az - AZ_OFFSET;
  assign w_az_sext = {{10{w_az_comp[15]}}, w_az_comp};
  assign w_prod    = w_az_sext * $signed(26'(ACC_GAIN));

  // Arithmetic shift leaves prod[25:13] sign-extended in the low 16 bits.
  assign o_ptch_acc = 16'(w_prod >>> 13);

endmodule

// File: rtl/incline_integrator.sv
// Gyro pitch-rate integrator with accel fusion; outputs upper 13 bits of the accumulator.
// Optional macro INTEG_CLAMP_EN saturates the accumulator instead of wrapping.
module incline_integrator
  import eBike_pkg::*;
#(
  parameter int unsigned SETTLE_SAMPLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vld,
  input  logic signed [15:0]          ptch_rt,
  input  logic signed [15:0]          AZ,
  output logic signed [INCLINE_W-1:0] incline,
  output logic                        incline_upd,
  output logic                        incline_rdy
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);

  logic signed [PTCH_INT_W-1:0] r_ptch_int;
  logic signed [INCLINE_W-1:0]  r_incline;
  logic                         r_upd;
  logic                         r_rdy;
  logic [7:0]                   r_settle_cnt;
  settle_state_e                r_state;

  logic signed [15:0]           w_ptch_rt_comp;
  logic signed [15:0]           w_ptch_acc;
  logic signed [PTCH_INT_W-1:0] w_fusion;
  logic signed [PTCH_INT_W-1:0] w_ptch_int_nxt;

  ptch_acc_calc u_ptch_acc_calc (
    .i_az       (AZ),
    .o_ptch_acc (w_ptch_acc)
  );

  assign w_ptch_rt_comp = ptch_rt - PTCH_RT_OFFSET;

  // Nudge the integrator toward the accel-derived pitch by a fixed step.
  assign w_fusion = (w_ptch_acc > $signed(r_ptch_int[26:11])) ?  $signed(27'(FUSION_STEP))
                                                              : -$signed(27'(FUSION_STEP));

`ifdef INTEG_CLAMP_EN
  localparam logic signed [27:0] SAT_MAX = 28'sh3FFFFFF;
  localparam logic signed [27:0] SAT_MIN = 28'shC000000;

  logic signed [27:0] w_sum_wide;

  assign w_sum_wide = {r_ptch_int[26], r_ptch_int}
                    - {{12{w_ptch_rt_comp[15]}}, w_ptch_rt_comp}
                    + {w_fusion[26], w_fusion};

  always_comb begin
    w_ptch_int_nxt = w_sum_wide[26:0];
    if (w_sum_wide > SAT_MAX) begin
      w_ptch_int_nxt = SAT_MAX[26:0];
    end else if (w_sum_wide < SAT_MIN) begin
      w_ptch_int_nxt = SAT_MIN[26:0];
    end
  end
`else
  assign w_ptch_int_nxt = r_ptch_int
                        - {{11{w_ptch_rt_comp[15]}}, w_ptch_rt_comp}
                        + w_fusion;
`endif

  // Accumulator, registered outputs and settle FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptch_int   <= '0;
      r_incline    <= '0;
      r_upd        <= 1'b0;
      r_rdy        <= 1'b0;
      r_settle_cnt <= '0;
      r_state      <= SETTLING;
    end else begin
      r_upd <= vld;
      if (vld) begin
        r_ptch_int <= w_ptch_int_nxt;
        r_incline  <= w_ptch_int_nxt[26:14];
        unique case (r_state)
          SETTLING: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state <= RUN;
              r_rdy   <= 1'b1;
            end else begin
              r_settle_cnt <= r_settle_cnt + 8'd1;
            end
          end
          RUN: begin
            r_state <= RUN;
          end
        endcase
      end
    end
  end

  assign incline     = r_incline;
  assign incline_upd = r_upd;
  assign incline_rdy = r_rdy;

endmodule

// File: tb/tb_incline_integrator.sv
// Self-checking bench for incline_integrator against an integer reference model.
module tb_incline_integrator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] az;
  logic [12:0] incline;
  logic        incline_upd;
  logic        incline_rdy;

  int n_checks = 0;
  int n_fails  = 0;

  longint      m_int;
  int          m_samples;
  logic [12:0] m_inc;
  logic        m_upd;

  incline_integrator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (vld),
    .ptch_rt     (ptch_rt),
    .AZ          (az),
    .incline     (incline),
    .incline_upd (incline_upd),
    .incline_rdy (incline_rdy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int s16(input int x);
    logic [15:0] t;
    t = 16'(x);
    return int'($signed(t));
  endfunction

  task automatic model_reset();
    m_int = 0; m_samples = 0; m_inc = '0; m_upd = 1'b0;
  endtask

  // Reference: integer arithmetic straight from the sample-update rules.
  task automatic model_step(input bit v, input logic [15:0] pr, input logic [15:0] a);
    int     rt_comp, az_comp, acc_pitch, fusion;
    longint nxt;
    logic [26:0] t27;
    m_upd = v;
    if (v) begin
      rt_comp   = s16(int'(pr) - 'h50);
      az_comp   = s16(s16(int'(a)) + 288);
      acc_pitch = (az_comp * 327) >>> 13;
      fusion    = (longint'(acc_pitch) > (m_int >>> 11)) ? 1024 : -1024;
      nxt       = m_int - rt_comp + fusion;
`ifdef INTEG_CLAMP_EN
      if (nxt > 67108863) nxt = 67108863;
      if (nxt < -67108864) nxt = -67108864;
      m_int = nxt;
`else
      t27   = 27'(nxt);
      m_int = longint'($signed(t27));
`endif
      m_inc = 13'(m_int >>> 14);
      m_samples++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".incline"}, 32'(incline), 32'(m_inc));
    check_val({tag, ".upd"}, 32'(incline_upd), 32'(m_upd));
    check_val({tag, ".rdy"}, 32'(incline_rdy), 32'(m_samples >= 8));
  endtask

  // Drive at negedge, model at posedge, compare at next negedge.
  task automatic do_cycle(input string tag, input bit v, input logic [15:0] pr, input logic [15:0] a);
    vld = v; ptch_rt = pr; az = a;
    @(posedge clk);
    model_step(v, pr, a);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val({tag, ".rst_incline"}, 32'(incline), 32'h0);
    check_val({tag, ".rst_upd"}, 32'(incline_upd), 32'h0);
    check_val({tag, ".rst_rdy"}, 32'(incline_rdy), 32'h0);
    vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int          upd_cnt;
    bit          wrapped;
    logic [12:0] prev;

    rst_n = 1'b0; vld = 1'b0; ptch_rt = '0; az = '0;
    model_reset();
    repeat (2) @(negedge clk);
    apply_reset("init");

    for (int i = 0; i < 20; i++) do_cycle("idle", 1'b0, 16'h0000, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      do_cycle("alt", 1'b1, 16'h0050, 16'hFEE0);
      check_val("alt.value", 32'(incline), (i % 2 == 0) ? 32'h1FFF : 32'h0);
      do_cycle("alt_gap", 1'b0, 16'h0050, 16'hFEE0);
    end

    apply_reset("ramp");
    upd_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      do_cycle("ramp", 1'b1, 16'h1050, 16'hFEE0);
      if (incline_upd) upd_cnt++;
      if (i == 7) check_val("ramp.rdy7", 32'(incline_rdy), 32'h0);
      if (i == 8) check_val("ramp.rdy8", 32'(incline_rdy), 32'h1);
      do_cycle("ramp_gap", 1'b0, 16'h1050, 16'hFEE0);
      if (incline_upd) upd_cnt++;
    end
    check_val("ramp.incline16", 32'(incline), 32'h1FFC);
    check_val("ramp.upd_count", 32'(upd_cnt), 32'd16);
    check_val("ramp.rdy_sticky", 32'(incline_rdy), 32'h1);

    for (int i = 0; i < 4; i++) do_cycle("burst", 1'b1, 16'h2345, 16'h0123);
    apply_reset("midburst");
    for (int i = 1; i <= 8; i++) begin
      do_cycle("refill", 1'b1, 16'(i * 97), 16'hFF00);
      check_val("refill.rdy", 32'(incline_rdy), 32'(i >= 8));
    end

    for (int i = 0; i < 500; i++)
      do_cycle("rand", ($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom));

    apply_reset("extreme");
    wrapped = 1'b0;
    prev    = incline;
    for (int i = 0; i < 16384; i++) begin
      do_cycle("extreme", 1'b1, 16'h8050, 16'hFEE0);
      if (!prev[12] && prev >= 13'h0F00 && incline[12]) wrapped = 1'b1;
      prev = incline;
    end
`ifdef INTEG_CLAMP_EN
    check_val("extreme.sat", 32'(incline), 32'h0FFF);
    check_val("extreme.wrap", 32'(wrapped), 32'h0);
`else
    check_val("extreme.wrap", 32'(wrapped), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
